// File: rtl/inst_buff_pkg.sv
// Shared types and sizing for the instruction buffer between fetch and dispatch.
package inst_buff_pkg;

  localparam int N = 3;
  localparam int INST_BUFF_DEPTH = 8;

  localparam int PTR_W = $clog2(INST_BUFF_DEPTH);
  localparam int CNT_W = $clog2(INST_BUFF_DEPTH + 1);
  localparam int NUM_W = $clog2(N + 1);

  typedef logic [PTR_W-1:0] IBUFF_PTR;

  typedef enum logic [1:0] {
    NO_BR_TASK = 2'd0,
    SQUASH     = 2'd1,
    PREDICT    = 2'd2
  } BR_TASK;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } INST_PACKET;

endpackage

// File: rtl/ibuff_ptr_add.sv
// Circular pointer add: (ptr + incr) mod INST_BUFF_DEPTH using compare-and-subtract,
// so depths that are not a power of two wrap correctly. Requires incr <= depth.
module ibuff_ptr_add
   import inst_buff_pkg::*;
(
   input  logic [PTR_W-1:0] ptr,
   input  logic [CNT_W-1:0] incr,
   output logic [PTR_W-1:0] sum
);

   logic [CNT_W:0] raw;

   always_comb begin
      raw = (CNT_W+1)'(ptr) + (CNT_W+1)'(incr);
      if (raw >= (CNT_W+1)'(INST_BUFF_DEPTH))
         sum = PTR_W'(raw - (CNT_W+1)'(INST_BUFF_DEPTH));
      else
         sum = PTR_W'(raw);
   end

endmodule

// File: rtl/inst_buff.sv
// Circular instruction FIFO: up to 4 packets in from fetch, up to N oldest out to dispatch.
// Define IBUFF_BYPASS_EN to forward fetch packets straight to dispatch when the buffer is empty.
module inst_buff
   import inst_buff_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   input  BR_TASK                 br_task,
   input  INST_PACKET [3:0]       in_insts,
   input  logic [2:0]             in_num_insts,
   input  logic [NUM_W-1:0]       dispatch_num,
   output INST_PACKET [N-1:0]     out_insts,
   output logic [NUM_W-1:0]       out_num_insts,
   output logic [CNT_W-1:0]       ibuff_open
);

   INST_PACKET       entries [INST_BUFF_DEPTH];
   IBUFF_PTR         head, tail, head_next, tail_next;
   logic [CNT_W-1:0] count, count_next;
   IBUFF_PTR         rd_idx [N];
   IBUFF_PTR         wr_idx [4];
   INST_PACKET       wr_data [4];

   logic             squash, bypass;
   logic [CNT_W-1:0] in_cnt, space, enq, disp_cnt, avail, out_cnt, deq;
   logic [CNT_W-1:0] skip, wr_cnt, head_incr;

   for (genvar i = 0; i < N; i++) begin : g_rd
      ibuff_ptr_add u_rd (.ptr(head), .incr(CNT_W'(i)), .sum(rd_idx[i]));
   end

   for (genvar k = 0; k < 4; k++) begin : g_wr
      ibuff_ptr_add u_wr (.ptr(tail), .incr(CNT_W'(k)), .sum(wr_idx[k]));
   end

   ibuff_ptr_add u_head (.ptr(head), .incr(head_incr), .sum(head_next));
   ibuff_ptr_add u_tail (.ptr(tail), .incr(wr_cnt),    .sum(tail_next));

   // Space is judged on the registered count only; same-cycle dispatch frees nothing.
   always_comb begin
      squash   = (br_task == SQUASH);
      in_cnt   = (in_num_insts > 3'd4) ? CNT_W'(4) : CNT_W'(in_num_insts);
      space    = CNT_W'(INST_BUFF_DEPTH) - count;
      enq      = (in_cnt < space) ? in_cnt : space;
      disp_cnt = CNT_W'(dispatch_num);
`ifdef IBUFF_BYPASS_EN
      bypass   = (count == '0) && !squash;
`else
      bypass   = 1'b0;
`endif
      avail    = bypass ? enq : count;
      if (squash)
         out_cnt = '0;
      else
         out_cnt = (avail < CNT_W'(N)) ? avail : CNT_W'(N);
      deq       = (disp_cnt < out_cnt) ? disp_cnt : out_cnt;
      skip      = bypass ? deq : '0;
      wr_cnt    = enq - skip;
      head_incr = bypass ? '0 : deq;
      count_next = count + wr_cnt - head_incr;

      out_num_insts = NUM_W'(out_cnt);
      for (int i = 0; i < N; i++) begin
         out_insts[i] = '0;
         if (CNT_W'(i) < out_cnt)
            out_insts[i] = bypass ? in_insts[i % 4] : entries[rd_idx[i]];
      end

      // Packets consumed through the bypass are skipped; the rest pack down from tail.
      for (int k = 0; k < 4; k++) begin
         wr_data[k] = '0;
         for (int j = 0; j < 4; j++)
            if (j == k + int'(skip))
               wr_data[k] = in_insts[j];
      end
   end

   assign ibuff_open = CNT_W'(INST_BUFF_DEPTH) - count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int e = 0; e < INST_BUFF_DEPTH; e++)
            entries[e] <= '0;
      end else if (squash) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         for (int k = 0; k < 4; k++)
            if (CNT_W'(k) < wr_cnt)
               entries[wr_idx[k]] <= wr_data[k];
         head  <= head_next;
         tail  <= tail_next;
         count <= count_next;
      end
   end

endmodule

// File: tb/tb_inst_buff.sv
// Directed bench for inst_buff at DEPTH=8, N=3; the bypass case runs only when
// IBUFF_BYPASS_EN is defined.
module tb_inst_buff;
   import inst_buff_pkg::*;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   BR_TASK             br_task = NO_BR_TASK;
   INST_PACKET [3:0]   in_insts = '0;
   logic [2:0]         in_num_insts = '0;
   logic [NUM_W-1:0]   dispatch_num = '0;
   INST_PACKET [N-1:0] out_insts;
   logic [NUM_W-1:0]   out_num_insts;
   logic [CNT_W-1:0]   ibuff_open;

   int n_cmp = 0;
   int n_bad = 0;

   inst_buff dut (
      .clock(clock), .reset(reset), .br_task(br_task),
      .in_insts(in_insts), .in_num_insts(in_num_insts), .dispatch_num(dispatch_num),
      .out_insts(out_insts), .out_num_insts(out_num_insts), .ibuff_open(ibuff_open)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int n, input logic [31:0] base, input int disp);
      for (int k = 0; k < 4; k++) begin
         in_insts[k] = '0;
         if (k < n) begin
            in_insts[k].valid = 1'b1;
            in_insts[k].pc    = base + 32'(4 * k);
            in_insts[k].inst  = 32'h0000_0013;
         end
      end
      in_num_insts = 3'(n);
      dispatch_num = NUM_W'(disp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #1 reset = 1'b1;
      step();
      check("rst_num",  out_num_insts, 0);
      check("rst_open", ibuff_open, 8);
      check("rst_pc0",  out_insts[0].pc, 0);
      reset = 1'b0;

      // fill from empty
      drive(4, 32'h0, 0);
      step();
      drive(4, 32'h10, 0);
      step();
      check("fill_open", ibuff_open, 0);
      check("fill_num",  out_num_insts, 3);
      check("fill_pc0",  out_insts[0].pc, 32'h0);
      check("fill_pc1",  out_insts[1].pc, 32'h4);
      check("fill_pc2",  out_insts[2].pc, 32'h8);

      // overflow while full: nothing written, 3 dispatched
      drive(4, 32'h80, 3);
      step();
      check("ovf_open", ibuff_open, 3);
      check("ovf_pc0",  out_insts[0].pc, 32'hC);
      check("ovf_pc1",  out_insts[1].pc, 32'h10);
      drive(0, 32'h0, 3);
      step();
      check("drain_num", out_num_insts, 2);
      check("drain_pc0", out_insts[0].pc, 32'h18);
      check("drain_pc1", out_insts[1].pc, 32'h1C);
      check("drain_pc2", out_insts[2].pc, 0);

      // clamp: count 2, dispatch 3
      step();
      check("clamp_num",  out_num_insts, 0);
      check("clamp_open", ibuff_open, 8);

      // move head/tail to 6 with an empty buffer
      drive(4, 32'h100, 0);
      step();
      drive(2, 32'h110, 0);
      step();
      check("six_open", ibuff_open, 2);
      check("six_pc0",  out_insts[0].pc, 32'h100);
      drive(0, 32'h0, 3);
      step();
      check("six_pc0b", out_insts[0].pc, 32'h10C);
      step();
      check("six_empty", out_num_insts, 0);

      // wrap: entries 6,7,0,1
      drive(4, 32'h40, 0);
`ifndef IBUFF_BYPASS_EN
      check("wrap_lat", out_num_insts, 0);
`endif
      step();
      drive(0, 32'h0, 0);
      check("wrap_open", ibuff_open, 4);
      check("wrap_pc0",  out_insts[0].pc, 32'h40);
      check("wrap_pc1",  out_insts[1].pc, 32'h44);
      check("wrap_pc2",  out_insts[2].pc, 32'h48);
      drive(0, 32'h0, 3);
      step();
      check("wrap_num1", out_num_insts, 1);
      check("wrap_pc3",  out_insts[0].pc, 32'h4C);
      step();
      check("wrap_done", out_num_insts, 0);

      // squash with count 5 and incoming packets
      drive(4, 32'h200, 0);
      step();
      drive(1, 32'h210, 0);
      step();
      check("sq_open_pre", ibuff_open, 3);
      br_task = SQUASH;
      drive(4, 32'h300, 3);
      #1;
      check("sq_num_now", out_num_insts, 0);
      step();
      br_task = NO_BR_TASK;
      drive(0, 32'h0, 0);
      check("sq_open", ibuff_open, 8);
      check("sq_num",  out_num_insts, 0);
      drive(1, 32'h500, 0);
      step();
      drive(0, 32'h0, 0);
      check("sq_restart_num", out_num_insts, 1);
      check("sq_restart_pc",  out_insts[0].pc, 32'h500);

      // async reset mid-cycle with count 6
      drive(4, 32'h600, 0);
      step();
      drive(1, 32'h610, 0);
      step();
      drive(0, 32'h0, 0);
      check("ar_open_pre", ibuff_open, 2);
      #3 reset = 1'b1;
      #1;
      check("ar_open", ibuff_open, 8);
      check("ar_num",  out_num_insts, 0);
      check("ar_pc0",  out_insts[0].pc, 0);
      #1 reset = 1'b0;
      step();
      check("ar_open_post", ibuff_open, 8);

`ifdef IBUFF_BYPASS_EN
      drive(4, 32'h700, 3);
      #1;
      check("byp_num", out_num_insts, 3);
      check("byp_pc0", out_insts[0].pc, 32'h700);
      check("byp_pc2", out_insts[2].pc, 32'h708);
      step();
      drive(0, 32'h0, 0);
      check("byp_open", ibuff_open, 7);
      check("byp_left", out_insts[0].pc, 32'h70C);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
